coin_dispatcher: RTL and testbench
==================================

# coin_dispatcher

Game-side controller driving the coin lane-select interface of the coin generator. Picks a pseudo-random lane, holds `o_active` while the coin descends, watches `in_position` and `o_sprite_hit` coming back, and scores a collection or a miss. Frames are paced by vertical sync, so the coin module always sees `o_active = 0` for whole frames between coins and re-initialises.

## Interface
- `COOLDOWN_FRAMES`, 30: frames with no coin between consecutive coins (≥1).
- `MISS_TIMEOUT`, 240: frames allowed in ACTIVE before the coin is declared missed (≥1).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `SCORE_W`, 16: score width.

- `i_clk` in 1: pixel/system clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_v_sync` in 1: vertical sync, same clock domain; a rising edge is one frame tick.
- `i_enable` in 1: game running.
- `i_sprite_hit` in 1: coin/sprite overlap flag from the coin generator.
- `i_in_position` in 1: coin is in the hittable band, from the coin generator.
- `o_active` out 3: lane select to the coin generator. 0 = none, 1 = left, 2 = mid, 3 = right. Bit 2 is always 0.
- `o_score` out SCORE_W: collected-coin score.
- `o_collect_pulse` out 1: one-cycle pulse on a collection.
- `o_miss_pulse` out 1: one-cycle pulse on a miss.
- `o_streak` out 3: consecutive-collect count. Present only with `COIN_STREAK_EN`.

## Operation
- Reset: state IDLE; LFSR = LFSR_SEED; all counters and all outputs are 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in every state except reset.
- Frame tick: `tick = i_v_sync & ~vs_q`, where `vs_q` is `i_v_sync` registered.
- States:
  - **IDLE**: `o_active = 0`. When `i_enable = 1`, go to COOLDOWN with the frame counter cleared.
  - **COOLDOWN**: count ticks. When the count reaches COOLDOWN_FRAMES, go to SPAWN.
  - **SPAWN**: sample `lfsr[1:0]`.
    - If 0, stay in SPAWN (re-roll next cycle).
    - Otherwise latch the lane, go to ACTIVE, and clear the frame counter.
  - **ACTIVE**: `o_active = lane`.
    - `i_in_position & i_sprite_hit` → COLLECT.
    - Else `i_in_position` → ARMED.
    - Else count ticks; when the count reaches MISS_TIMEOUT → MISS.
  - **ARMED**: `o_active = lane`.
    - `i_in_position & i_sprite_hit` → COLLECT.
    - `~i_in_position` → MISS.
    - No timeout in this state.
  - **COLLECT** (1 cycle): `o_active = 0`, `o_collect_pulse = 1`, score += 1, saturating at all-ones. Then COOLDOWN with the counter cleared.
  - **MISS** (1 cycle): `o_active = 0`, `o_miss_pulse = 1`, score unchanged. Then COOLDOWN with the counter cleared.
- `i_sprite_hit` without `i_in_position` is ignored in all states.
- `i_enable = 0` from any state: IDLE on the next edge, `o_active` → 0, pulses 0, score held. A COLLECT or MISS already entered completes on that edge.

## Timing
- All outputs are registered and change on the same edge as the state transition.
- `o_active` is nonzero exactly while the state is ACTIVE or ARMED.
- Hit sampled at edge N in ACTIVE/ARMED: at edge N+1 the state is COLLECT, `o_active = 0`, the pulse is high and `o_score` is already incremented. At edge N+2 the pulse is low.
- A tick is recognised the cycle after `i_v_sync` is first sampled high. Cooldown duration is exactly COOLDOWN_FRAMES ticks.
- Cooldown ≥ 1 frame guarantees `o_active = 0` is visible across at least one full frame between coins.
- SPAWN takes 1 cycle, plus one cycle per zero roll.
- Asynchronous reset mid-coin: `o_active`, score, pulses and LFSR return to reset values immediately. No pulse is emitted.

## Configuration
- `COIN_STREAK_EN` defined:
  - `o_streak` exists. It increments on each collect, saturates at 7, and clears on MISS or reset.
  - A collect while `o_streak ≥ 3` (before the increment) adds 2 to the score instead of 1, still saturating.
- `COIN_STREAK_EN` not defined: no streak logic and no `o_streak` port. Every collect adds 1.

## Test plan
- Reset with COOLDOWN_FRAMES=2, then `i_enable=1` and 2 v_sync pulses → SPAWN. With `lfsr[1:0]=2'b00` the block re-rolls; the first nonzero roll drives `o_active ∈ {1,2,3}` the next cycle.
- In ACTIVE, raise `i_in_position`, then `i_sprite_hit` 5 cycles later → one-cycle `o_collect_pulse`, `o_score` 0→1, `o_active` → 0 on the same edge.
- In ARMED, drop `i_in_position` with no hit → `o_miss_pulse` for one cycle, score unchanged, then COOLDOWN.
- MISS_TIMEOUT=3 with `i_in_position` held 0 → after 3 ticks in ACTIVE, `o_miss_pulse = 1`.
- SCORE_W=4 with score preloaded to 15 via 15 collects, then one more collect → score stays 15. With `COIN_STREAK_EN`, the 4th consecutive collect from 0 gives score 5 and streak 4.
- Assert `i_rst` while `o_active = 2` → `o_active = 0` and `o_score = 0` before the next clock edge.

Source files
------------

// File: rtl/coin_dispatcher.sv
// coin_dispatcher: vsync-paced coin lane selector with collect/miss scoring.
// Defining COIN_STREAK_EN adds the o_streak port and the streak score bonus.
module coin_dispatcher #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned MISS_TIMEOUT    = 240,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned SCORE_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_v_sync,
  input  logic               i_enable,
  input  logic               i_sprite_hit,
  input  logic               i_in_position,
  output logic [2:0]         o_active,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_collect_pulse,
  output logic               o_miss_pulse
`ifdef COIN_STREAK_EN
  ,
  output logic [2:0]         o_streak
`endif
);

  localparam int unsigned CNT_MAX = (COOLDOWN_FRAMES > MISS_TIMEOUT) ? COOLDOWN_FRAMES : MISS_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] MT_LAST = CNT_W'(MISS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COOLDOWN = 3'd1,
    S_SPAWN    = 3'd2,
    S_ACTIVE   = 3'd3,
    S_ARMED    = 3'd4,
    S_COLLECT  = 3'd5,
    S_MISS     = 3'd6
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic               vs_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lane_q, lane_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         active_q, active_d;
  logic               collect_q, collect_d;
  logic               miss_q, miss_d;
  logic [SCORE_W:0]   gain_s;
  logic [SCORE_W:0]   sum_s;
  logic               tick_s;
  logic               hit_s;
`ifdef COIN_STREAK_EN
  logic [2:0]         streak_q, streak_d;
`endif

  assign tick_s = i_v_sync & ~vs_q;
  assign hit_s  = i_in_position & i_sprite_hit;

  // Next-state, counter, score and registered-output selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    score_d = score_q;
    gain_s  = (SCORE_W+1)'(1);
`ifdef COIN_STREAK_EN
    streak_d = streak_q;
    if (streak_q >= 3'd3) begin
      gain_s = (SCORE_W+1)'(2);
    end else begin
      gain_s = (SCORE_W+1)'(1);
    end
`endif
    sum_s = {1'b0, score_q} + gain_s;

    if (!i_enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COOLDOWN;
          cnt_d   = '0;
        end
        S_COOLDOWN: begin
          if (tick_s && (cnt_q == CD_LAST)) begin
            state_d = S_SPAWN;
          end else if (tick_s) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_SPAWN: begin
          // A zero roll has no lane meaning; wait for the LFSR to move on
          if (lfsr_q[1:0] != 2'd0) begin
            lane_d  = lfsr_q[1:0];
            cnt_d   = '0;
            state_d = S_ACTIVE;
          end else begin
            state_d = S_SPAWN;
          end
        end
        S_ACTIVE: begin
          if (hit_s) begin
            state_d = S_COLLECT;
          end else if (i_in_position) begin
            state_d = S_ARMED;
          end else if (tick_s && (cnt_q == MT_LAST)) begin
            state_d = S_MISS;
          end else if (tick_s) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_ARMED: begin
          if (hit_s) begin
            state_d = S_COLLECT;
          end else if (!i_in_position) begin
            state_d = S_MISS;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_COLLECT, S_MISS: begin
          state_d = S_COOLDOWN;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Score and streak only move on the edge that enters COLLECT/MISS
    if (state_d == S_COLLECT) begin
      score_d = sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
`ifdef COIN_STREAK_EN
      streak_d = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
`endif
    end else if (state_d == S_MISS) begin
      score_d = score_q;
`ifdef COIN_STREAK_EN
      streak_d = 3'd0;
`endif
    end else begin
      score_d = score_q;
    end

    active_d  = ((state_d == S_ACTIVE) || (state_d == S_ARMED)) ? {1'b0, lane_d} : 3'd0;
    collect_d = (state_d == S_COLLECT);
    miss_d    = (state_d == S_MISS);
  end

  // State, LFSR and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      vs_q      <= 1'b0;
      cnt_q     <= '0;
      lane_q    <= 2'd0;
      score_q   <= '0;
      active_q  <= 3'd0;
      collect_q <= 1'b0;
      miss_q    <= 1'b0;
`ifdef COIN_STREAK_EN
      streak_q  <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      vs_q      <= i_v_sync;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      score_q   <= score_d;
      active_q  <= active_d;
      collect_q <= collect_d;
      miss_q    <= miss_d;
`ifdef COIN_STREAK_EN
      streak_q  <= streak_d;
`endif
    end
  end

  assign o_active        = active_q;
  assign o_score         = score_q;
  assign o_collect_pulse = collect_q;
  assign o_miss_pulse    = miss_q;
`ifdef COIN_STREAK_EN
  assign o_streak        = streak_q;
`endif

endmodule

// File: tb/tb_coin_dispatcher.sv
// Randomized bench for coin_dispatcher against a frame/coin-level reference model.
module tb_coin_dispatcher;

  localparam int CD   = 2;
  localparam int MT   = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
`ifdef COIN_STREAK_EN
  localparam bit STREAK_ON = 1'b1;
`else
  localparam bit STREAK_ON = 1'b0;
`endif

  // Model phases of a coin's life
  localparam int P_IDLE = 0, P_WAIT = 1, P_ROLL = 2, P_FALL = 3, P_BAND = 4, P_GOT = 5, P_LOST = 6;

  logic          i_clk, i_rst, i_v_sync, i_enable, i_sprite_hit, i_in_position;
  logic [2:0]    o_active;
  logic [SW-1:0] o_score;
  logic          o_collect_pulse, o_miss_pulse;
`ifdef COIN_STREAK_EN
  logic [2:0]    o_streak;
`endif

  coin_dispatcher #(
    .COOLDOWN_FRAMES(CD),
    .MISS_TIMEOUT(MT),
    .LFSR_SEED(16'hACE1),
    .SCORE_W(SW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_v_sync(i_v_sync),
    .i_enable(i_enable),
    .i_sprite_hit(i_sprite_hit),
    .i_in_position(i_in_position),
    .o_active(o_active),
    .o_score(o_score),
    .o_collect_pulse(o_collect_pulse),
    .o_miss_pulse(o_miss_pulse)
`ifdef COIN_STREAK_EN
    ,
    .o_streak(o_streak)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;
  int n_collects = 0;
  int n_misses = 0;

  int m_phase, m_frames, m_lane, m_score, m_streak;
  bit [15:0] m_lfsr;
  bit m_vs;
  int e_active, e_collect, e_miss;

  int vs_left = 0;
  int vs_hi = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_frames = 0; m_lane = 0; m_score = 0; m_streak = 0;
    m_lfsr = 16'hACE1; m_vs = 1'b0;
    e_active = 0; e_collect = 0; e_miss = 0;
  endtask

  task automatic model_edge(input bit en, input bit vs, input bit pos, input bit hit);
    bit tick = vs && !m_vs;
    int roll = int'(m_lfsr[1:0]);
    int nxt = m_phase;
    if (!en) nxt = P_IDLE;
    else begin
      case (m_phase)
        P_IDLE: begin nxt = P_WAIT; m_frames = 0; end
        P_WAIT: if (tick) begin m_frames++; if (m_frames == CD) nxt = P_ROLL; end
        P_ROLL: if (roll != 0) begin m_lane = roll; m_frames = 0; nxt = P_FALL; end
        P_FALL: begin
          if (pos && hit) nxt = P_GOT;
          else if (pos) nxt = P_BAND;
          else if (tick) begin m_frames++; if (m_frames == MT) nxt = P_LOST; end
        end
        P_BAND: begin
          if (pos && hit) nxt = P_GOT;
          else if (!pos) nxt = P_LOST;
        end
        default: begin nxt = P_WAIT; m_frames = 0; end
      endcase
    end
    e_collect = (nxt == P_GOT) ? 1 : 0;
    e_miss = (nxt == P_LOST) ? 1 : 0;
    if (nxt == P_GOT) begin
      m_score = m_score + ((STREAK_ON && m_streak >= 3) ? 2 : 1);
      if (m_score > SMAX) m_score = SMAX;
      if (m_streak < 7) m_streak++;
      n_collects++;
    end
    if (nxt == P_LOST) begin
      m_streak = 0;
      n_misses++;
    end
    e_active = (nxt == P_FALL || nxt == P_BAND) ? m_lane : 0;
    m_phase = nxt;
    m_vs = vs;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic compare_all();
    check("active", 32'(o_active), 32'(e_active));
    check("score", 32'(o_score), 32'(m_score));
    check("collect_pulse", 32'(o_collect_pulse), 32'(e_collect));
    check("miss_pulse", 32'(o_miss_pulse), 32'(e_miss));
`ifdef COIN_STREAK_EN
    check("streak", 32'(o_streak), 32'(m_streak));
`endif
  endtask

  task automatic drive(input int p_flip, input int p_hit, input bit en);
    if (vs_left == 0) begin
      vs_left = int'($urandom_range(9, 5));
      vs_hi = int'($urandom_range(2, 1));
    end
    i_v_sync = (vs_left <= vs_hi);
    vs_left--;
    if (int'($urandom_range(99, 0)) < p_flip) i_in_position = ~i_in_position;
    i_sprite_hit = (int'($urandom_range(99, 0)) < p_hit);
    i_enable = en;
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge(i_enable, i_v_sync, i_in_position, i_sprite_hit);
    #1;
    compare_all();
  endtask

  initial begin
    bit found;
    int waited;
    i_rst = 1'b1; i_v_sync = 1'b0; i_enable = 1'b0; i_sprite_hit = 1'b0; i_in_position = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    compare_all();
    i_rst = 1'b0;

    // No in_position ever: every coin must time out after MT frames
    i_in_position = 1'b0;
    for (int i = 0; i < 250; i++) begin
      drive(0, 40, 1'b1);
      step();
    end

    // Mixed traffic with occasional enable drops
    for (int i = 0; i < 600; i++) begin
      drive(25, 20, int'($urandom_range(99, 0)) >= 3);
      step();
    end

    // Collect-heavy traffic to drive the score into saturation
    for (int i = 0; i < 700; i++) begin
      drive(40, 60, 1'b1);
      step();
    end
    check("saturated_score", 32'(o_score), 32'(SMAX));

    // Wait (bounded) for a mid-lane coin, then reset asynchronously
    i_in_position = 1'b0;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 600) begin
      if (o_active == 3'd2) found = 1'b1;
      else begin
        drive(0, 0, 1'b1);
        step();
        waited++;
      end
    end
    check("saw_lane2", 32'(found), 32'd1);
    i_rst = 1'b1;
    #1;
    model_reset();
    check("rst_active", 32'(o_active), 32'd0);
    check("rst_score", 32'(o_score), 32'd0);
    check("rst_pulses", 32'({o_collect_pulse, o_miss_pulse}), 32'd0);
    @(posedge i_clk);
    #1;
    compare_all();
    i_rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive(30, 30, int'($urandom_range(99, 0)) >= 2);
      step();
    end

    check("some_collects", 32'(n_collects > 0), 32'd1);
    check("some_misses", 32'(n_misses > 0), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
